// File: rtl/alu_seq_pkg.sv
// Shared definitions for the ALU operation sequencer: opcodes, FSM states and FIFO entry width.
// The OP_CHAIN field is only stored when ALU_SEQ_CHAIN_EN is defined.
package alu_seq_pkg;

  localparam logic [1:0] OP_ADD  = 2'b00;
  localparam logic [1:0] OP_AND  = 2'b01;
  localparam logic [1:0] OP_NOT  = 2'b10;
  localparam logic [1:0] OP_ZERO = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_HOLD  = 2'd2
  } state_e;

`ifdef ALU_SEQ_CHAIN_EN
  localparam int unsigned CHAIN_BITS = 1;
`else
  localparam int unsigned CHAIN_BITS = 0;
`endif

  // Entry layout, LSB first: A, B, opcode, optional chain flag.
  function automatic int unsigned entry_width(input int unsigned width);
    return 2 * width + 2 + CHAIN_BITS;
  endfunction

endpackage

// File: rtl/alu_seq_fifo.sv
// Synchronous FIFO for queued ALU operations; DEPTH must be a power of two so the
// pointers wrap naturally. Push when full and pop when empty are ignored.
module alu_seq_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned EW    = 10,
  localparam int unsigned AW   = $clog2(DEPTH)
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          push_i,
  input  logic [EW-1:0] wdata_i,
  input  logic          pop_i,
  output logic [EW-1:0] rdata_o,
  output logic          full_o,
  output logic          empty_o,
  output logic [AW:0]   level_o
);

  logic [EW-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   level_q, level_d;
  logic          do_push, do_pop;

  assign full_o  = (level_q == (AW+1)'(DEPTH));
  assign empty_o = (level_q == '0);
  assign level_o = level_q;
  assign rdata_o = mem_q[rd_ptr_q];

  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    unique case ({do_push, do_pop})
      2'b10:   level_d = level_q + (AW+1)'(1);
      2'b01:   level_d = level_q - (AW+1)'(1);
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // Storage needs no reset: only entries below the level are ever read.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/alu_op_sequencer.sv
// Feeds queued operations one at a time to a 4-bit toggle-gated ALU and presents each result
// on a valid/ready port. Define ALU_SEQ_CHAIN_EN to let an op take the last result as operand A.
module alu_op_sequencer
  import alu_seq_pkg::*;
#(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned DEPTH = 4,
  localparam int unsigned LW   = $clog2(DEPTH) + 1
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             OP_VALID,
  output logic             OP_READY,
  input  logic [WIDTH-1:0] OP_A,
  input  logic [WIDTH-1:0] OP_B,
  input  logic [1:0]       OP_CODE,
  input  logic             OP_CHAIN,
  output logic [WIDTH-1:0] ALU_IN1,
  output logic [WIDTH-1:0] ALU_IN2,
  output logic [1:0]       ALU_CTRL,
  output logic             ALU_TOGGLE,
  input  logic [WIDTH-1:0] ALU_OUT,
  input  logic             ALU_CF,
  input  logic             ALU_Z,
  output logic             RES_VALID,
  input  logic             RES_READY,
  output logic [WIDTH-1:0] RES_DATA,
  output logic             RES_CF,
  output logic             RES_Z,
  output logic [1:0]       RES_OPCODE,
  output logic [LW-1:0]    FIFO_LEVEL
);

  localparam int unsigned EW = entry_width(WIDTH);

  logic [EW-1:0]    fifo_wdata, fifo_rdata;
  logic             fifo_full, fifo_empty, fifo_push, fifo_pop;
  logic [WIDTH-1:0] head_a, head_b;
  logic [1:0]       head_code;
  logic [WIDTH-1:0] head_in1;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] in1_q, in1_d, in2_q, in2_d;
  logic [1:0]       ctrl_q, ctrl_d;
  logic             toggle_q, toggle_d;
  logic             res_valid_q, res_valid_d;
  logic [WIDTH-1:0] res_data_q, res_data_d;
  logic             res_cf_q, res_cf_d;
  logic             res_z_q, res_z_d;
  logic [1:0]       res_op_q, res_op_d;

  assign head_a    = fifo_rdata[WIDTH-1:0];
  assign head_b    = fifo_rdata[2*WIDTH-1:WIDTH];
  assign head_code = fifo_rdata[2*WIDTH+1:2*WIDTH];

`ifdef ALU_SEQ_CHAIN_EN
  assign fifo_wdata = {OP_CHAIN, OP_CODE, OP_B, OP_A};
  // res_data_q is still the previous op's result whenever a pop happens.
  assign head_in1   = fifo_rdata[2*WIDTH+2] ? res_data_q : head_a;
`else
  logic unused_chain;
  assign unused_chain = OP_CHAIN;
  assign fifo_wdata   = {OP_CODE, OP_B, OP_A};
  assign head_in1     = head_a;
`endif

  assign OP_READY  = !fifo_full;
  assign fifo_push = OP_VALID && !fifo_full;

  alu_seq_fifo #(
    .DEPTH (DEPTH),
    .EW    (EW)
  ) u_fifo (
    .clk_i   (CLK),
    .rst_ni  (RST_N),
    .push_i  (fifo_push),
    .wdata_i (fifo_wdata),
    .pop_i   (fifo_pop),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .level_o (FIFO_LEVEL)
  );

  always_comb begin
    state_d     = state_q;
    in1_d       = in1_q;
    in2_d       = in2_q;
    ctrl_d      = ctrl_q;
    toggle_d    = 1'b0;
    res_valid_d = res_valid_q;
    res_data_d  = res_data_q;
    res_cf_d    = res_cf_q;
    res_z_d     = res_z_q;
    res_op_d    = res_op_q;
    fifo_pop    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          in1_d    = head_in1;
          in2_d    = head_b;
          ctrl_d   = head_code;
          toggle_d = 1'b1;
          state_d  = S_ISSUE;
        end
      end
      S_ISSUE: begin
        res_data_d  = ALU_OUT;
        res_cf_d    = ALU_CF;
        res_z_d     = ALU_Z;
        res_op_d    = ctrl_q;
        res_valid_d = 1'b1;
        state_d     = S_HOLD;
      end
      S_HOLD: begin
        if (RES_READY) begin
          res_valid_d = 1'b0;
          if (!fifo_empty) begin
            fifo_pop = 1'b1;
            in1_d    = head_in1;
            in2_d    = head_b;
            ctrl_d   = head_code;
            toggle_d = 1'b1;
            state_d  = S_ISSUE;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q     <= S_IDLE;
      in1_q       <= '0;
      in2_q       <= '0;
      ctrl_q      <= '0;
      toggle_q    <= 1'b0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      res_cf_q    <= 1'b0;
      res_z_q     <= 1'b0;
      res_op_q    <= '0;
    end else begin
      state_q     <= state_d;
      in1_q       <= in1_d;
      in2_q       <= in2_d;
      ctrl_q      <= ctrl_d;
      toggle_q    <= toggle_d;
      res_valid_q <= res_valid_d;
      res_data_q  <= res_data_d;
      res_cf_q    <= res_cf_d;
      res_z_q     <= res_z_d;
      res_op_q    <= res_op_d;
    end
  end

  assign ALU_IN1    = in1_q;
  assign ALU_IN2    = in2_q;
  assign ALU_CTRL   = ctrl_q;
  assign ALU_TOGGLE = toggle_q;
  assign RES_VALID  = res_valid_q;
  assign RES_DATA   = res_data_q;
  assign RES_CF     = res_cf_q;
  assign RES_Z      = res_z_q;
  assign RES_OPCODE = res_op_q;

endmodule
